dial_zero_solver: RTL and testbench
===================================

Name: dial_zero_solver

Overview:
- Parametrised successor to the one-step-per-cycle dial solver.
- Accepts rotation commands (direction, step count) over a valid/ready handshake and updates a modular dial.
- Counts two things in parallel: rotations that end on 0 (land count) and every click that shows 0, including mid-rotation passes (pass count).
- Skips whole revolutions in one cycle each, so a rotation of N steps occupies the block for floor(N/MOD)+1 cycles instead of N.

Parameters:
- INPUT_WIDTH, 10, width of step_count.
- COUNT_WIDTH, 16, width of each result counter.
- DIAL_INIT, 50, dial value after reset.
- DIAL_MAX, 99, highest dial position (inclusive); MOD = DIAL_MAX+1.
- DIAL_WIDTH, 7, width of dial register; must satisfy 2^DIAL_WIDTH > DIAL_MAX.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command present
- in_ready  out  1  block idle and able to accept
- step_direction  in  1  1 = up (R), 0 = down (L)
- step_count  in  INPUT_WIDTH  clicks to rotate
- dial  out  DIAL_WIDTH  current dial position
- land_count  out  COUNT_WIDTH  rotations ending at 0
- pass_count  out  COUNT_WIDTH  clicks at which dial showed 0
- done  out  1  one-cycle pulse when a command retires
- overflow  out  1  sticky; set when either counter saturates

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, dial=DIAL_INIT, land_count=0, pass_count=0, done=0, overflow=0, in_ready=1.
  - Reset overrides everything; a command in flight is discarded.
- Handshake:
  - A command is accepted when in_valid && in_ready at a clk edge.
  - On acceptance, latch dir and rem=step_count, then go to ROTATE.
  - in_ready=1 only in IDLE. in_valid while busy is ignored; upstream holds the command until accepted.
- ROTATE, evaluated each cycle:
  - If rem >= MOD: rem -= MOD, pass_count += 1, dial unchanged, stay in ROTATE. A full revolution shows 0 exactly once.
  - Else (final cycle), resolve the remainder r=rem (< MOD) as follows, then go to IDLE.
- Final-cycle dial update:
  - Up: s = dial + r. If s >= MOD: dial = s - MOD and pass_count += 1. Otherwise dial = s.
  - Down, r == 0: no change.
  - Down, dial == 0: dial = MOD - r, no pass.
  - Down, r >= dial: pass_count += 1, dial = (dial - r) mod MOD.
  - Down, otherwise: dial = dial - r.
- Final-cycle counting and done:
  - If the updated dial == 0 and the original step_count != 0: land_count += 1.
  - done=1 on the final cycle's following edge, i.e. registered, high for exactly one cycle in IDLE.
- step_count=0: one ROTATE cycle, no counter or dial change, done still pulses.
- Latency:
  - Accept at edge E; command retires at edge E+floor(N/MOD)+1.
  - in_ready is high again the cycle after retirement.
  - Back-to-back commands can be accepted one cycle apart when N < MOD.
- Arithmetic and saturation:
  - All dial arithmetic is done at DIAL_WIDTH+1 bits.
  - Counters saturate at all-ones and do not wrap. An increment attempted at saturation sets overflow, which stays set until rst.
  - A same-cycle pass and land increment are independent.

Decomposition:
- Package dial_pkg holds:
  - Function/localparam for MOD.
  - State enum {IDLE, ROTATE}.
  - Saturating-increment function shared by both counters.
- Sub-module dial_remainder_step:
  - Purely combinational.
  - Inputs: dial, dir, r.
  - Outputs: next_dial, pass_inc.
  - Exhaustively testable on its own.
- Top of the solver holds the FSM, rem register, counters and handshake.

Test Plan:
- Puzzle example from reset (dial 50): L68 L30 R48 L5 R60 L55 L1 L99 R14 L82, one command per in_ready -> land_count=3, pass_count=6, final dial=32.
- R1000 from 50 -> 11 busy cycles (in_ready low for 11), pass_count=10, land_count=0, dial=50, single done pulse.
- Boundaries from 50:
  - L50 -> dial=0, land=1, pass=1.
  - Then L0 -> no change, done pulses.
  - Then L1 -> dial=99, pass still 1.
  - Then R1 -> dial=0, land=2, pass=2.
- Saturation with COUNT_WIDTH=3: eight R100 commands -> pass_count saturates at 7 on the seventh command. Overflow sets on the eighth and stays set through further commands.
- Reset mid-operation: R900, assert rst on the 3rd ROTATE cycle -> next cycle dial=50, counts=0, in_ready=1, no done pulse. A following R50 yields land=1.
- Handshake: hold in_valid high with a changing command while busy -> only the value present at the in_ready=1 edge is taken, and busy-period commands are ignored.

Source files
------------

// File: rtl/dial_pkg.sv
// Shared definitions for the dial zero solver: modulus helper, FSM states,
// and the saturating counter increment used by both result counters.
package dial_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } dial_state_e;

  function automatic int dial_mod(input int dial_max);
    return dial_max + 1;
  endfunction

  // Holds at all-ones of the given width instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int width);
    logic [63:0] top;
    top = (64'd1 << width) - 64'd1;
    return (v == top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/dial_remainder_step.sv
// Resolves the final partial rotation (r < MOD) of a command in one step,
// reporting whether the dial showed 0 along the way.
module dial_remainder_step
  import dial_pkg::*;
#(
  parameter int DIAL_MAX   = 99,
  parameter int DIAL_WIDTH = 7
) (
  input  logic [DIAL_WIDTH-1:0] dial,
  input  logic                  dir,
  input  logic [DIAL_WIDTH-1:0] r,
  output logic [DIAL_WIDTH-1:0] next_dial,
  output logic                  pass_inc
);

  localparam logic [DIAL_WIDTH:0] MOD_W = (DIAL_WIDTH+1)'(dial_mod(DIAL_MAX));

  logic [DIAL_WIDTH:0] d, rr, s, res;

  always_comb begin
    d        = {1'b0, dial};
    rr       = {1'b0, r};
    s        = d + rr;
    res      = d;
    pass_inc = 1'b0;
    if (dir) begin
      res = s;
      if (s >= MOD_W) begin
        res      = s - MOD_W;
        pass_inc = 1'b1;
      end
    end else if (rr == '0) begin
      res = d;
    end else if (d == '0) begin
      // Leaving 0 downward never returns to 0 within less than a revolution.
      res = MOD_W - rr;
    end else if (rr >= d) begin
      pass_inc = 1'b1;
      res      = (rr == d) ? '0 : d + MOD_W - rr;
    end else begin
      res = d - rr;
    end
    next_dial = res[DIAL_WIDTH-1:0];
  end

endmodule

// File: rtl/dial_zero_solver.sv
// Modular dial solver: one cycle per whole revolution plus one cycle for the
// remainder, counting landings on 0 and every click that shows 0.
module dial_zero_solver
  import dial_pkg::*;
#(
  parameter int INPUT_WIDTH = 10,
  parameter int COUNT_WIDTH = 16,
  parameter int DIAL_INIT   = 50,
  parameter int DIAL_MAX    = 99,
  parameter int DIAL_WIDTH  = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   step_direction,
  input  logic [INPUT_WIDTH-1:0] step_count,
  output logic [DIAL_WIDTH-1:0]  dial,
  output logic [COUNT_WIDTH-1:0] land_count,
  output logic [COUNT_WIDTH-1:0] pass_count,
  output logic                   done,
  output logic                   overflow
);

  localparam int                   MOD     = dial_mod(DIAL_MAX);
  localparam logic [INPUT_WIDTH:0] MOD_CMP = (INPUT_WIDTH+1)'(MOD);
  localparam logic [INPUT_WIDTH-1:0] MOD_SUB = INPUT_WIDTH'(MOD);

  dial_state_e state, state_n;
  logic [INPUT_WIDTH-1:0] rem, rem_n;
  logic dir, dir_n, nonzero, nonzero_n;
  logic [DIAL_WIDTH-1:0] dial_n, step_dial;
  logic [COUNT_WIDTH-1:0] land_n, pass_n;
  logic done_n, overflow_n, step_pass, pass_inc, land_inc;
  logic [INPUT_WIDTH+DIAL_WIDTH-1:0] rem_ext;
  logic [63:0] land_sat, pass_sat;

  assign rem_ext  = {{DIAL_WIDTH{1'b0}}, rem};
  assign in_ready = (state == IDLE);

  dial_remainder_step #(
    .DIAL_MAX  (DIAL_MAX),
    .DIAL_WIDTH(DIAL_WIDTH)
  ) u_step (
    .dial     (dial),
    .dir      (dir),
    .r        (rem_ext[DIAL_WIDTH-1:0]),
    .next_dial(step_dial),
    .pass_inc (step_pass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rem        <= '0;
      dir        <= 1'b0;
      nonzero    <= 1'b0;
      dial       <= DIAL_WIDTH'(DIAL_INIT);
      land_count <= '0;
      pass_count <= '0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      rem        <= rem_n;
      dir        <= dir_n;
      nonzero    <= nonzero_n;
      dial       <= dial_n;
      land_count <= land_n;
      pass_count <= pass_n;
      done       <= done_n;
      overflow   <= overflow_n;
    end
  end

  always_comb begin
    state_n    = state;
    rem_n      = rem;
    dir_n      = dir;
    nonzero_n  = nonzero;
    dial_n     = dial;
    done_n     = 1'b0;
    pass_inc   = 1'b0;
    land_inc   = 1'b0;
    overflow_n = overflow;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          dir_n     = step_direction;
          rem_n     = step_count;
          nonzero_n = |step_count;
          state_n   = ROTATE;
        end
      end
      ROTATE: begin
        if ({1'b0, rem} >= MOD_CMP) begin
          // Whole revolution: dial returns to itself having shown 0 once.
          rem_n    = rem - MOD_SUB;
          pass_inc = 1'b1;
        end else begin
          dial_n   = step_dial;
          pass_inc = step_pass;
          land_inc = nonzero && (step_dial == '0);
          done_n   = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    land_sat = sat_inc({{(64-COUNT_WIDTH){1'b0}}, land_count}, COUNT_WIDTH);
    pass_sat = sat_inc({{(64-COUNT_WIDTH){1'b0}}, pass_count}, COUNT_WIDTH);
    land_n   = land_inc ? land_sat[COUNT_WIDTH-1:0] : land_count;
    pass_n   = pass_inc ? pass_sat[COUNT_WIDTH-1:0] : pass_count;
    if ((land_inc && (&land_count)) || (pass_inc && (&pass_count)))
      overflow_n = 1'b1;
  end

endmodule

// File: tb/tb_dial_zero_solver.sv
// Drives two solvers (16-bit and 3-bit counters) with identical commands and
// compares them to a click-by-click model of the dial.
module tb_dial_zero_solver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic step_direction = 1'b0;
  logic [9:0] step_count = '0;

  logic ready_a, done_a, ovf_a, ready_b, done_b, ovf_b;
  logic [6:0] dial_a, dial_b;
  logic [15:0] land_a, pass_a;
  logic [2:0] land_b, pass_b;

  int total = 0;
  int bad = 0;

  // Reference state: unbounded dial model, per-DUT saturating counters.
  int m_dial;
  int m_land[2];
  int m_pass[2];
  bit m_ovf[2];
  int cmax[2] = '{65535, 7};

  always #5 clk = ~clk;

  dial_zero_solver u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .step_direction(step_direction), .step_count(step_count),
    .dial(dial_a), .land_count(land_a), .pass_count(pass_a),
    .done(done_a), .overflow(ovf_a)
  );

  dial_zero_solver #(.COUNT_WIDTH(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .step_direction(step_direction), .step_count(step_count),
    .dial(dial_b), .land_count(land_b), .pass_count(pass_b),
    .done(done_b), .overflow(ovf_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_dial = 50;
    for (int k = 0; k < 2; k++) begin
      m_land[k] = 0;
      m_pass[k] = 0;
      m_ovf[k]  = 1'b0;
    end
  endfunction

  function automatic void bump(inout int cnt, input int k);
    if (cnt == cmax[k]) m_ovf[k] = 1'b1;
    else cnt++;
  endfunction

  function automatic void model_cmd(input bit up, input int n);
    for (int i = 0; i < n; i++) begin
      m_dial = up ? (m_dial + 1) % 100 : (m_dial + 99) % 100;
      if (m_dial == 0)
        for (int k = 0; k < 2; k++) bump(m_pass[k], k);
    end
    if (n != 0 && m_dial == 0)
      for (int k = 0; k < 2; k++) bump(m_land[k], k);
  endfunction

  task automatic compare_state(input string tag);
    check({tag, ".dial_a"}, int'(dial_a), m_dial);
    check({tag, ".land_a"}, int'(land_a), m_land[0]);
    check({tag, ".pass_a"}, int'(pass_a), m_pass[0]);
    check({tag, ".ovf_a"},  int'(ovf_a),  int'(m_ovf[0]));
    check({tag, ".dial_b"}, int'(dial_b), m_dial);
    check({tag, ".land_b"}, int'(land_b), m_land[1]);
    check({tag, ".pass_b"}, int'(pass_b), m_pass[1]);
    check({tag, ".ovf_b"},  int'(ovf_b),  int'(m_ovf[1]));
  endtask

  // Called at a sample point (#1 after an edge) with the DUT idle.
  // With junk set, in_valid stays high carrying random commands while busy.
  task automatic send(input string tag, input bit up, input int n, input bit junk);
    int cyc;
    int waitc;
    waitc = 0;
    while (!ready_a && waitc < 2000) begin
      @(posedge clk); #1; waitc++;
    end
    if (!ready_a) begin
      check({tag, ".ready_timeout"}, 0, 1);
      return;
    end
    in_valid = 1'b1;
    step_direction = up;
    step_count = 10'(n);
    @(posedge clk); #1;
    model_cmd(up, n);
    check({tag, ".busy"}, int'(ready_a), 0);
    cyc = 0;
    in_valid = 1'b0;
    while (cyc < 2000) begin
      if (junk) begin
        in_valid = 1'b1;
        step_direction = 1'($urandom);
        step_count = 10'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (done_a) break;
      if (ready_a) check({tag, ".ready_while_busy"}, 1, 0);
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, cyc, n / 100 + 1);
    check({tag, ".done_b"}, int'(done_b), 1);
    check({tag, ".ready_at_done"}, int'(ready_a), 1);
    compare_state(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit dirs[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};
    int nums[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};

    do_reset();
    check("reset.ready", int'(ready_a), 1);
    check("reset.done", int'(done_a), 0);
    compare_state("reset");

    for (int i = 0; i < 10; i++) send("puzzle", dirs[i], nums[i], 1'b0);
    check("puzzle.land_total", int'(land_a), 3);
    check("puzzle.pass_total", int'(pass_a), 6);
    check("puzzle.dial_final", int'(dial_a), 32);

    do_reset();
    send("r1000", 1'b1, 1000, 1'b0);
    @(posedge clk); #1;
    check("r1000.done_single", int'(done_a), 0);
    check("r1000.pass", int'(pass_a), 10);
    check("r1000.dial", int'(dial_a), 50);

    do_reset();
    send("l50", 1'b0, 50, 1'b0);
    check("l50.land", int'(land_a), 1);
    send("l0", 1'b0, 0, 1'b0);
    check("l0.dial", int'(dial_a), 0);
    send("l1", 1'b0, 1, 1'b0);
    check("l1.dial", int'(dial_a), 99);
    send("r1", 1'b1, 1, 1'b0);
    check("r1.land", int'(land_a), 2);
    check("r1.pass", int'(pass_a), 2);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      send("sat", 1'b1, 100, 1'b0);
      if (i == 6) begin
        check("sat.pass7", int'(pass_b), 7);
        check("sat.ovf_clear", int'(ovf_b), 0);
      end
    end
    check("sat.ovf_set", int'(ovf_b), 1);
    send("sat_more", 1'b1, 250, 1'b0);
    check("sat.ovf_sticky", int'(ovf_b), 1);

    do_reset();
    in_valid = 1'b1;
    step_direction = 1'b1;
    step_count = 10'd900;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("midrst.ready", int'(ready_a), 1);
    check("midrst.done", int'(done_a), 0);
    compare_state("midrst");
    send("midrst_r50", 1'b1, 50, 1'b0);
    check("midrst_r50.land", int'(land_a), 1);

    do_reset();
    send("hs_first", 1'b1, 250, 1'b1);
    send("hs_second", 1'b0, 37, 1'b1);
    send("hs_third", 1'b0, 463, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                      : int'($urandom_range(0, 120));
      send("rand", 1'($urandom), n, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
